// File: rtl/avalon_packetizer.sv
// avalon_packetizer
// Frames a flat stream of payload words into Avalon-ST packets. A byte length is
// accepted while idle; exactly ceil(len/DATA_WIDTH_IN_BYTES) words are then passed
// straight through to the packet port. The first word carries sop. The last word
// carries eop and the count of unused bytes in empty.
// Zero-length requests are consumed and flagged with a one-cycle len_err pulse.

module avalon_packetizer #(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // packet length request
  input  logic [LEN_WIDTH-1:0]                 cfg_len,
  input  logic                                 cfg_len_valid,
  output logic                                 cfg_len_rdy,
  // raw payload stream
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0]     in_data,
  input  logic                                 in_valid,
  output logic                                 in_rdy,
  // Avalon-ST packet master (flattened packet_msg bundle)
  output logic [8*DATA_WIDTH_IN_BYTES-1:0]     packet_msg_data,
  output logic                                 packet_msg_valid,
  input  logic                                 packet_msg_rdy,
  output logic                                 packet_msg_sop,
  output logic                                 packet_msg_eop,
  output logic [((DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1)-1:0] packet_msg_empty,
  // status pulses
  output logic                                 len_err,
  output logic                                 pkt_done
);

  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  // Word size and unit count expressed in the length domain so all length
  // arithmetic stays LEN_WIDTH wide and never overflows.
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);
  localparam logic [LEN_WIDTH-1:0] ONE_L   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] ZERO_L  = {LEN_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
  logic [EMPTY_W-1:0]   empty_last_q, empty_last_d;
  logic                 first_word_q, first_word_d;
  logic                 len_err_q, len_err_d;
  logic                 pkt_done_q, pkt_done_d;

  // Length decode: quotient plus a round-up unit rather than (len + B - 1) / B,
  // so the all-ones length cannot wrap.
  logic [LEN_WIDTH-1:0] len_quot_s;
  logic [LEN_WIDTH-1:0] len_rem_s;
  logic                 len_rem_nz_s;
  logic [LEN_WIDTH-1:0] len_words_s;
  logic [EMPTY_W-1:0]   len_empty_s;

  // Convert the offered byte length into a word count and trailing empty bytes.
  always_comb begin
    len_quot_s   = cfg_len / BYTES_L;
    len_rem_s    = cfg_len % BYTES_L;
    len_rem_nz_s = (len_rem_s != ZERO_L);
    len_words_s  = len_quot_s + {{(LEN_WIDTH-1){1'b0}}, len_rem_nz_s};
    if (len_rem_nz_s) begin
      len_empty_s = EMPTY_W'(BYTES_L - len_rem_s);
    end else begin
      len_empty_s = {EMPTY_W{1'b0}};
    end
  end

  // State register and per-packet bookkeeping; reset returns to IDLE at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      words_left_q <= ZERO_L;
      empty_last_q <= {EMPTY_W{1'b0}};
      first_word_q <= 1'b0;
      len_err_q    <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      empty_last_q <= empty_last_d;
      first_word_q <= first_word_d;
      len_err_q    <= len_err_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  // Next-state logic and the combinational pass-through of the payload stream.
  always_comb begin
    state_d          = state_q;
    words_left_d     = words_left_q;
    empty_last_d     = empty_last_q;
    first_word_d     = first_word_q;
    len_err_d        = 1'b0;
    pkt_done_d       = 1'b0;
    cfg_len_rdy      = 1'b0;
    in_rdy           = 1'b0;
    packet_msg_valid = 1'b0;
    packet_msg_data  = {DATA_W{1'b0}};
    packet_msg_sop   = 1'b0;
    packet_msg_eop   = 1'b0;
    packet_msg_empty = {EMPTY_W{1'b0}};

    case (state_q)
      IDLE: begin
        cfg_len_rdy = 1'b1;
        if (cfg_len_valid) begin
          if (cfg_len != ZERO_L) begin
            words_left_d = len_words_s;
            empty_last_d = len_empty_s;
            first_word_d = 1'b1;
            state_d      = SEND;
          end else begin
            // Zero-length request: consume it, report, stay idle.
            len_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        packet_msg_valid = in_valid;
        packet_msg_data  = in_data;
        in_rdy           = packet_msg_rdy;
        packet_msg_sop   = in_valid & first_word_q;
        packet_msg_eop   = in_valid & (words_left_q == ONE_L);
        if (packet_msg_eop) begin
          packet_msg_empty = empty_last_q;
        end else begin
          packet_msg_empty = {EMPTY_W{1'b0}};
        end

        if (in_valid && packet_msg_rdy) begin
          first_word_d = 1'b0;
          words_left_d = words_left_q - ONE_L;
          if (words_left_q == ONE_L) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign len_err  = len_err_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_avalon_packetizer.sv
// Bench for avalon_packetizer with 8-byte words: directed corner packets plus
// randomized lengths, bubbles and backpressure, checked against a word-count
// model derived from byte arithmetic.

module tb_avalon_packetizer;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_len;
  logic        cfg_len_valid;
  logic        cfg_len_rdy;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_rdy;
  logic [63:0] packet_msg_data;
  logic        packet_msg_valid;
  logic        packet_msg_rdy;
  logic        packet_msg_sop;
  logic        packet_msg_eop;
  logic [2:0]  packet_msg_empty;
  logic        len_err;
  logic        pkt_done;

  int n_cmp;
  int n_err;

  avalon_packetizer #(
    .DATA_WIDTH_IN_BYTES(8),
    .LEN_WIDTH(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_len          (cfg_len),
    .cfg_len_valid    (cfg_len_valid),
    .cfg_len_rdy      (cfg_len_rdy),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_rdy           (in_rdy),
    .packet_msg_data  (packet_msg_data),
    .packet_msg_valid (packet_msg_valid),
    .packet_msg_rdy   (packet_msg_rdy),
    .packet_msg_sop   (packet_msg_sop),
    .packet_msg_eop   (packet_msg_eop),
    .packet_msg_empty (packet_msg_empty),
    .len_err          (len_err),
    .pkt_done         (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one packet of len bytes. Enters and leaves one time step after a rising edge
  // with the DUT idle. Junk lengths are offered during the packet and must be ignored.
  task automatic run_packet(input int len, input int stall_pct, input int bubble_pct,
                            input int fixed_stall);
    int nwords;
    int exp_empty;
    int k;
    int cycles;
    int forced;
    logic v;
    logic r;
    logic [63:0] d;
    logic exp_sop;
    logic exp_eop;
    nwords    = (len + 7) / 8;
    exp_empty = nwords * 8 - len;

    cfg_len        = 16'(len);
    cfg_len_valid  = 1'b1;
    in_valid       = 1'b1;
    in_data        = {$urandom, $urandom};
    packet_msg_rdy = 1'b1;
    @(negedge clk);
    chk("idle_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b1));
    chk("idle_in_rdy", 64'(in_rdy), 64'(1'b0));
    chk("idle_valid", 64'(packet_msg_valid), 64'(1'b0));
    chk("idle_data", packet_msg_data, 64'h0);
    @(posedge clk); #1;

    k      = 0;
    cycles = 0;
    forced = 0;
    while (k < nwords && cycles < 20000) begin
      v = (int'($urandom_range(99)) >= bubble_pct);
      r = (int'($urandom_range(99)) >= stall_pct);
      if (k == 1 && forced < fixed_stall) begin
        v = 1'b1;
        r = 1'b0;
        forced++;
      end
      d              = {$urandom, $urandom};
      in_valid       = v;
      packet_msg_rdy = r;
      in_data        = d;
      cfg_len_valid  = 1'($urandom_range(1));
      cfg_len        = 16'($urandom_range(65535));
      exp_sop        = v && (k == 0);
      exp_eop        = v && (k == nwords - 1);
      @(negedge clk);
      chk("send_valid", 64'(packet_msg_valid), 64'(v));
      chk("send_in_rdy", 64'(in_rdy), 64'(r));
      chk("send_data", packet_msg_data, d);
      chk("send_sop", 64'(packet_msg_sop), 64'(exp_sop));
      chk("send_eop", 64'(packet_msg_eop), 64'(exp_eop));
      chk("send_empty", 64'(packet_msg_empty), exp_eop ? 64'(exp_empty) : 64'h0);
      chk("send_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b0));
      chk("send_pkt_done", 64'(pkt_done), 64'(1'b0));
      if (v && r) k++;
      cycles++;
      @(posedge clk); #1;
    end
    chk("pkt_words", 64'(k), 64'(nwords));

    cfg_len_valid  = 1'b0;
    in_valid       = 1'b1;
    packet_msg_rdy = 1'b1;
    @(negedge clk);
    chk("done_pulse", 64'(pkt_done), 64'(1'b1));
    chk("done_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b1));
    chk("done_valid", 64'(packet_msg_valid), 64'(1'b0));
    chk("done_in_rdy", 64'(in_rdy), 64'(1'b0));
    chk("done_len_err", 64'(len_err), 64'(1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", 64'(pkt_done), 64'(1'b0));
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b0;
    cfg_len        = 16'd0;
    cfg_len_valid  = 1'b0;
    in_valid       = 1'b1;
    in_data        = 64'hDEAD_BEEF_0123_4567;
    packet_msg_rdy = 1'b1;

    // Reset state
    #3;
    chk("rst_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b1));
    chk("rst_in_rdy", 64'(in_rdy), 64'(1'b0));
    chk("rst_valid", 64'(packet_msg_valid), 64'(1'b0));
    chk("rst_sop", 64'(packet_msg_sop), 64'(1'b0));
    chk("rst_eop", 64'(packet_msg_eop), 64'(1'b0));
    chk("rst_empty", 64'(packet_msg_empty), 64'h0);
    chk("rst_data", packet_msg_data, 64'h0);
    chk("rst_len_err", 64'(len_err), 64'(1'b0));
    chk("rst_pkt_done", 64'(pkt_done), 64'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed packets: multi-word, partial last word, single word, stalled
    run_packet(16, 0, 0, 0);
    run_packet(13, 0, 0, 0);
    run_packet(5, 0, 0, 0);
    run_packet(24, 0, 0, 3);
    run_packet(1, 0, 0, 0);
    run_packet(8, 0, 0, 0);
    run_packet(9, 0, 0, 0);

    // Zero length: consumed, len_err pulse, no packet started
    cfg_len       = 16'd0;
    cfg_len_valid = 1'b1;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    cfg_len_valid = 1'b0;
    @(negedge clk);
    chk("zero_len_err", 64'(len_err), 64'(1'b1));
    chk("zero_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b1));
    chk("zero_valid", 64'(packet_msg_valid), 64'(1'b0));
    chk("zero_in_rdy", 64'(in_rdy), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_len_err_end", 64'(len_err), 64'(1'b0));
    chk("zero_still_idle", 64'(cfg_len_rdy), 64'(1'b1));
    @(posedge clk); #1;

    // Reset mid-packet after word0 of a 24-byte packet
    cfg_len        = 16'd24;
    cfg_len_valid  = 1'b1;
    in_valid       = 1'b0;
    packet_msg_rdy = 1'b1;
    @(posedge clk); #1;
    cfg_len_valid = 1'b0;
    in_valid      = 1'b1;
    in_data       = {$urandom, $urandom};
    @(negedge clk);
    chk("mid_w0_sop", 64'(packet_msg_sop), 64'(1'b1));
    @(posedge clk); #1;
    in_data = {$urandom, $urandom};
    @(negedge clk);
    chk("mid_w1_valid", 64'(packet_msg_valid), 64'(1'b1));
    chk("mid_w1_sop", 64'(packet_msg_sop), 64'(1'b0));
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(packet_msg_valid), 64'(1'b0));
    chk("mid_rst_eop", 64'(packet_msg_eop), 64'(1'b0));
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'(1'b0));
    chk("mid_rst_cfg_rdy", 64'(cfg_len_rdy), 64'(1'b1));
    chk("mid_rst_data", packet_msg_data, 64'h0);
    @(posedge clk); #1;
    chk("mid_rst_pkt_done", 64'(pkt_done), 64'(1'b0));
    chk("mid_rst_len_err", 64'(len_err), 64'(1'b0));
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    run_packet(8, 0, 0, 0);

    // Maximum length, no overflow in the word count
    run_packet(65535, 0, 0, 0);

    // Randomized lengths with bubbles and backpressure
    for (int i = 0; i < 60; i++) begin
      int len;
      if (i % 10 == 0) begin
        len = int'($urandom_range(65535, 65000));
      end else begin
        len = int'($urandom_range(80, 1));
      end
      run_packet(len, 30, 20, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
